// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline.
// Contents:
//   MIPS_DATA_W     default datapath width
//   MIPS_REG_ADDR_W default register-index width
//   REG_ZERO        index of the hard-wired zero register
//   occ_state_t     occupancy of a pipeline stage with an optional skid entry
package mips_pkg;

    localparam int MIPS_DATA_W     = 32;
    localparam int MIPS_REG_ADDR_W = 5;
    localparam int REG_ZERO        = 0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/mem_wb_entry.sv
// One MEM->WB payload register: control bits, load data, ALU result,
// destination register and the pre-selected write-back value.
// Ports:
//   clk, reset          clock, asynchronous active-high reset (clears all fields)
//   load                capture the d_* fields this cycle
//   clear_we            force the stored reg_write to 0 (used for squash)
//   d_reg_write ..      payload to capture
//   d_wb_data
//   q_reg_write ..      stored payload
//   q_wb_data
module mem_wb_entry #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear_we,
    input  logic                  d_reg_write,
    input  logic                  d_mem_to_reg,
    input  logic [DATA_W-1:0]     d_mem_data,
    input  logic [DATA_W-1:0]     d_alu_result,
    input  logic [REG_ADDR_W-1:0] d_rd,
    input  logic [DATA_W-1:0]     d_wb_data,
    output logic                  q_reg_write,
    output logic                  q_mem_to_reg,
    output logic [DATA_W-1:0]     q_mem_data,
    output logic [DATA_W-1:0]     q_alu_result,
    output logic [REG_ADDR_W-1:0] q_rd,
    output logic [DATA_W-1:0]     q_wb_data
);

    // A squash wins over a load so a flushed entry can never write the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg_write  <= 1'b0;
            q_mem_to_reg <= 1'b0;
            q_mem_data   <= '0;
            q_alu_result <= '0;
            q_rd         <= '0;
            q_wb_data    <= '0;
        end else begin
            if (load) begin
                q_reg_write  <= d_reg_write;
                q_mem_to_reg <= d_mem_to_reg;
                q_mem_data   <= d_mem_data;
                q_alu_result <= d_alu_result;
                q_rd         <= d_rd;
                q_wb_data    <= d_wb_data;
            end
            if (clear_we) begin
                q_reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, flush and an optional
// skid entry. WB sees the registered MEM payload, a pre-muxed wb_data and a
// gated write enable; a saturating counter records back-pressure cycles.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   flush                      synchronous squash of all held entries
//   in_valid / in_ready        MEM-side handshake
//   in_reg_write .. in_rd      MEM-stage payload
//   out_valid / out_ready      WB-side handshake
//   out_reg_write .. out_rd    registered payload (reg_write forced 0 for rd==0)
//   wb_data                    registered mem_to_reg ? mem_data : alu_result
//   wb_we                      out_valid & out_reg_write & out_ready
//   stall_cnt                  saturating count of out_valid & !out_ready cycles
module mem_wb_pipe_stage
    import mips_pkg::*;
#(
    parameter int DATA_W      = MIPS_DATA_W,
    parameter int REG_ADDR_W  = MIPS_REG_ADDR_W,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_reg_write,
    input  logic                   in_mem_to_reg,
    input  logic [DATA_W-1:0]      in_mem_data,
    input  logic [DATA_W-1:0]      in_alu_result,
    input  logic [REG_ADDR_W-1:0]  in_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_reg_write,
    output logic                   out_mem_to_reg,
    output logic [DATA_W-1:0]      out_mem_data,
    output logic [DATA_W-1:0]      out_alu_result,
    output logic [REG_ADDR_W-1:0]  out_rd,
    output logic [DATA_W-1:0]      wb_data,
    output logic                   wb_we,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    occ_state_t state, state_next;
    logic accept, retire;
    logic main_load, main_from_skid, skid_load;

    logic                  cap_reg_write;
    logic [DATA_W-1:0]     cap_wb_data;

    logic                  skid_reg_write, skid_mem_to_reg;
    logic [DATA_W-1:0]     skid_mem_data, skid_alu_result, skid_wb_data;
    logic [REG_ADDR_W-1:0] skid_rd;

    logic                  main_d_reg_write, main_d_mem_to_reg;
    logic [DATA_W-1:0]     main_d_mem_data, main_d_alu_result, main_d_wb_data;
    logic [REG_ADDR_W-1:0] main_d_rd;

    assign accept    = in_valid & in_ready;
    assign out_valid = (state != OCC_EMPTY);
    assign retire    = out_valid & out_ready;
    assign wb_we     = out_valid & out_reg_write & out_ready;

    // Writes to r0 are neutralised and the write-back value is chosen once,
    // at capture, so WB never waits on a mux behind the register.
    assign cap_reg_write = in_reg_write & (in_rd != REG_ADDR_W'(REG_ZERO));
    assign cap_wb_data   = in_mem_to_reg ? in_mem_data : in_alu_result;

    assign main_d_reg_write  = main_from_skid ? skid_reg_write  : cap_reg_write;
    assign main_d_mem_to_reg = main_from_skid ? skid_mem_to_reg : in_mem_to_reg;
    assign main_d_mem_data   = main_from_skid ? skid_mem_data   : in_mem_data;
    assign main_d_alu_result = main_from_skid ? skid_alu_result : in_alu_result;
    assign main_d_rd         = main_from_skid ? skid_rd         : in_rd;
    assign main_d_wb_data    = main_from_skid ? skid_wb_data    : cap_wb_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy: main always holds the oldest entry; the skid entry only
    // fills when a new instruction arrives while WB is stalled.
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_next = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_next = OCC_ONE;
                        main_load  = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && retire) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        if (SKID != 0) begin
                            state_next = OCC_TWO;
                            skid_load  = 1'b1;
                        end
                    end else if (retire) begin
                        state_next = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (retire) begin
                        state_next     = OCC_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = OCC_EMPTY;
                end
            endcase
        end
    end

    mem_wb_entry #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) main (
        .clk          (clk),
        .reset        (reset),
        .load         (main_load),
        .clear_we     (flush),
        .d_reg_write  (main_d_reg_write),
        .d_mem_to_reg (main_d_mem_to_reg),
        .d_mem_data   (main_d_mem_data),
        .d_alu_result (main_d_alu_result),
        .d_rd         (main_d_rd),
        .d_wb_data    (main_d_wb_data),
        .q_reg_write  (out_reg_write),
        .q_mem_to_reg (out_mem_to_reg),
        .q_mem_data   (out_mem_data),
        .q_alu_result (out_alu_result),
        .q_rd         (out_rd),
        .q_wb_data    (wb_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            mem_wb_entry #(
                .DATA_W     (DATA_W),
                .REG_ADDR_W (REG_ADDR_W)
            ) skid (
                .clk          (clk),
                .reset        (reset),
                .load         (skid_load),
                .clear_we     (flush),
                .d_reg_write  (cap_reg_write),
                .d_mem_to_reg (in_mem_to_reg),
                .d_mem_data   (in_mem_data),
                .d_alu_result (in_alu_result),
                .d_rd         (in_rd),
                .d_wb_data    (cap_wb_data),
                .q_reg_write  (skid_reg_write),
                .q_mem_to_reg (skid_mem_to_reg),
                .q_mem_data   (skid_mem_data),
                .q_alu_result (skid_alu_result),
                .q_rd         (skid_rd),
                .q_wb_data    (skid_wb_data)
            );

            // Registered ready breaks the combinational path from WB back to MEM.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_next != OCC_TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_reg_write  = 1'b0;
            assign skid_mem_to_reg = 1'b0;
            assign skid_mem_data   = '0;
            assign skid_alu_result = '0;
            assign skid_rd         = '0;
            assign skid_wb_data    = '0;
            assign in_ready        = !out_valid | out_ready;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Testbench for mem_wb_pipe_stage. Two instances share one input stream:
// index 0 is the single-entry variant with a 2-bit stall counter, index 1 the
// skid variant with the default 16-bit counter. Each has its own queue-based
// reference model; a negedge monitor compares every presented entry.
module tb_mem_wb_pipe_stage;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] wb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_reg_write = 1'b0;
    logic        in_mem_to_reg = 1'b0;
    logic [31:0] in_mem_data = '0;
    logic [31:0] in_alu_result = '0;
    logic [4:0]  in_rd = '0;
    logic        out_ready = 1'b0;

    logic        inRdy [2];
    logic        outValid [2];
    logic        outRw [2];
    logic        outM2r [2];
    logic [31:0] outMem [2];
    logic [31:0] outAlu [2];
    logic [4:0]  outRd [2];
    logic [31:0] wbA [2];
    logic        weA [2];
    logic [1:0]  stall0;
    logic [15:0] stall1;
    logic [31:0] stallA [2];

    exp_t        sb [2][$];
    int          cnt [2];
    int          cntMax [2];
    bit          pushPend [2];
    bit          flushPend [2];
    bit          stallPend [2];
    bit          rwClear [2];
    bit          rstClear [2];

    int          testsRun = 0;
    int          failCount = 0;

    assign stallA[0] = 32'(stall0);
    assign stallA[1] = 32'(stall1);

    always #5 clk = ~clk;

    mem_wb_pipe_stage #(
        .DATA_W      (32),
        .REG_ADDR_W  (5),
        .SKID        (0),
        .STALL_CNT_W (2)
    ) dut0 (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (inRdy[0]),
        .in_reg_write   (in_reg_write),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_mem_data    (in_mem_data),
        .in_alu_result  (in_alu_result),
        .in_rd          (in_rd),
        .out_valid      (outValid[0]),
        .out_ready      (out_ready),
        .out_reg_write  (outRw[0]),
        .out_mem_to_reg (outM2r[0]),
        .out_mem_data   (outMem[0]),
        .out_alu_result (outAlu[0]),
        .out_rd         (outRd[0]),
        .wb_data        (wbA[0]),
        .wb_we          (weA[0]),
        .stall_cnt      (stall0)
    );

    mem_wb_pipe_stage #(
        .DATA_W      (32),
        .REG_ADDR_W  (5),
        .SKID        (1),
        .STALL_CNT_W (16)
    ) dut1 (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (inRdy[1]),
        .in_reg_write   (in_reg_write),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_mem_data    (in_mem_data),
        .in_alu_result  (in_alu_result),
        .in_rd          (in_rd),
        .out_valid      (outValid[1]),
        .out_ready      (out_ready),
        .out_reg_write  (outRw[1]),
        .out_mem_to_reg (outM2r[1]),
        .out_mem_data   (outMem[1]),
        .out_alu_result (outAlu[1]),
        .out_rd         (outRd[1]),
        .wb_data        (wbA[1]),
        .wb_we          (weA[1]),
        .stall_cnt      (stall1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic m2r,
                                 input logic [31:0] mem, input logic [31:0] alu,
                                 input logic [4:0] rd, input logic ordy, input logic fl);
        in_valid      = v;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        in_mem_data   = mem;
        in_alu_result = alu;
        in_rd         = rd;
        out_ready     = ordy;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, ordy, 1'b0);
    endtask

    // Reference model: each stage is a FIFO of at most 1 or 2 entries; the
    // expected in_ready comes straight from the stage's handshake rule.
    exp_t e;
    int   occ;
    bit   expRdy;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                sb[i].delete();
                cnt[i]       = 0;
                pushPend[i]  = 1'b0;
                flushPend[i] = 1'b0;
                stallPend[i] = 1'b0;
                rwClear[i]   = 1'b1;
                rstClear[i]  = 1'b1;
            end else begin
                occ    = sb[i].size();
                expRdy = (i == 1) ? (occ < 2) : ((occ == 0) || out_ready);
                checkOutput($sformatf("s%0d in_ready", i), 32'(inRdy[i]), 32'(expRdy));
                checkOutput($sformatf("s%0d out_valid", i), 32'(outValid[i]), 32'(occ != 0));
                checkOutput($sformatf("s%0d stall_cnt", i), stallA[i], 32'(cnt[i]));
                if (occ != 0) begin
                    e = sb[i][0];
                    checkOutput($sformatf("s%0d out_rd", i), 32'(outRd[i]), 32'(e.rd));
                    checkOutput($sformatf("s%0d out_reg_write", i), 32'(outRw[i]), 32'(e.rw));
                    checkOutput($sformatf("s%0d out_mem_to_reg", i), 32'(outM2r[i]), 32'(e.m2r));
                    checkOutput($sformatf("s%0d out_mem_data", i), outMem[i], e.mem);
                    checkOutput($sformatf("s%0d out_alu_result", i), outAlu[i], e.alu);
                    checkOutput($sformatf("s%0d wb_data", i), wbA[i], e.wb);
                    checkOutput($sformatf("s%0d wb_we", i), 32'(weA[i]), 32'(e.rw & out_ready));
                end else begin
                    checkOutput($sformatf("s%0d wb_we idle", i), 32'(weA[i]), 32'(0));
                    if (rwClear[i]) begin
                        checkOutput($sformatf("s%0d out_reg_write cleared", i), 32'(outRw[i]), 32'(0));
                    end
                    if (rstClear[i]) begin
                        checkOutput($sformatf("s%0d wb_data reset", i), wbA[i], 32'(0));
                        checkOutput($sformatf("s%0d out_rd reset", i), 32'(outRd[i]), 32'(0));
                        checkOutput($sformatf("s%0d out_alu reset", i), outAlu[i], 32'(0));
                    end
                end
                stallPend[i] = (occ != 0) && !out_ready;
                if ((occ != 0) && out_ready && !flush) begin
                    void'(sb[i].pop_front());
                end
                pushPend[i]  = in_valid && expRdy && !flush;
                flushPend[i] = flush;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (flushPend[i]) begin
                    sb[i].delete();
                    rwClear[i] = 1'b1;
                end else if (pushPend[i]) begin
                    exp_t n;
                    n.rw  = in_reg_write && (in_rd != 5'd0);
                    n.m2r = in_mem_to_reg;
                    n.mem = in_mem_data;
                    n.alu = in_alu_result;
                    n.rd  = in_rd;
                    n.wb  = in_mem_to_reg ? in_mem_data : in_alu_result;
                    sb[i].push_back(n);
                    rwClear[i]  = 1'b0;
                    rstClear[i] = 1'b0;
                end
                if (stallPend[i] && (cnt[i] < cntMax[i])) begin
                    cnt[i] = cnt[i] + 1;
                end
            end
        end
    end

    initial begin
        cntMax[0] = 3;
        cntMax[1] = 65535;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Plain ALU write, then a load to r0 that must not write.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010, 5'd5, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0055, 5'd0, 1'b1, 1'b0);
        idle(1'b1);

        // Two arrivals under back-pressure, then release.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00A1, 5'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00B2, 5'd2, 1'b0, 1'b0);
        idle(1'b0);
        repeat (3) idle(1'b1);

        // Continuous input with out_ready toggling 1010.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b1, k[0], 32'hC000_0000 + 32'(k), 32'hA000_0000 + 32'(k),
                          5'(k + 3), ~k[0], 1'b0);
        end
        repeat (3) idle(1'b1);

        // Fill, then flush together with out_ready and a new input.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0007, 5'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0008, 5'd8, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0009, 5'd9, 1'b1, 1'b1);
        repeat (2) idle(1'b1);

        // Long stall to saturate the narrow counter, then async reset mid-stall.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_000A, 5'd10, 1'b0, 1'b0);
        repeat (6) idle(1'b0);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("s%0d async out_valid", i), 32'(outValid[i]), 32'(0));
            checkOutput($sformatf("s%0d async wb_data", i), wbA[i], 32'(0));
            checkOutput($sformatf("s%0d async wb_we", i), 32'(weA[i]), 32'(0));
            checkOutput($sformatf("s%0d async stall_cnt", i), stallA[i], 32'(0));
            checkOutput($sformatf("s%0d async out_rd", i), 32'(outRd[i]), 32'(0));
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomised traffic with one reset in the middle.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                reset = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b0;
            end
            applyStimulus(($urandom % 10) < 7, ($urandom % 4) != 0, $urandom % 2,
                          $urandom, $urandom, 5'($urandom_range(0, 31)),
                          ($urandom % 10) < 6, ($urandom % 25) == 0);
        end

        repeat (4) idle(1'b1);
        checkOutput("s0 drained", 32'(sb[0].size()), 32'(0));
        checkOutput("s1 drained", 32'(sb[1].size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
